// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM states, drain default and the
// per-stage enable/clear bundle driven onto the pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, WAIT_MDU, DRAIN, HALTED} state_t;

  localparam int DRAIN_CYCLES_DEF = 3;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic ifid_bb;
    logic idex_en;
    logic idex_clr;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0, ifid_bb: 1'b0,
                                 idex_en: 1'b1, idex_clr: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};
  localparam ctrl_t CTRL_OFF = '0;

  // Freeze PC and IF/ID, inject a bubble into EX; back end keeps draining.
  function automatic ctrl_t hold_front(input ctrl_t c);
    ctrl_t r;
    r          = c;
    r.pc_en    = 1'b0;
    r.ifid_en  = 1'b0;
    r.ifid_bb  = 1'b0;
    r.idex_clr = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX writes a register the ID instruction reads.
// Purely combinational; register 0 never creates a hazard.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       lu_stall
);

  assign lu_stall = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables/clears for stalls, flushes, MDU waits and
// halt/resume; outputs are combinational from state and ID/EX inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             id_mdu_req,
  input  logic             mdu_done,
  input  logic             id_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             ifid_bb,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             mdu_start,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 2);

  state_t        state, state_nxt;
  ctrl_t         ctl;
  logic [DW-1:0] drain_cnt;
  logic          drain_ld;
  logic          stall_ev;
  logic          flush_ev;
  logic          mdu_fin;
  logic          lu_stall;

  hazard_detect u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .lu_stall   (lu_stall)
  );

  // mdu_fin masks the still-present mult/div in ID for the cycle it leaves.
  always_comb begin
    ctl       = CTRL_RUN;
    state_nxt = state;
    drain_ld  = 1'b0;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    mdu_start = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (ex_br_taken) begin
            ctl.ifid_clr = 1'b1;
            ctl.idex_clr = 1'b1;
            flush_ev     = 1'b1;
          end else if (lu_stall) begin
            ctl      = hold_front(CTRL_RUN);
            stall_ev = 1'b1;
          end else if (id_mdu_req && !mdu_fin) begin
            ctl       = hold_front(CTRL_RUN);
            stall_ev  = 1'b1;
            mdu_start = 1'b1;
            state_nxt = WAIT_MDU;
          end else if (id_halt) begin
            ctl       = hold_front(CTRL_RUN);
            drain_ld  = 1'b1;
            state_nxt = DRAIN;
          end
        end
        WAIT_MDU: begin
          ctl      = hold_front(CTRL_RUN);
          stall_ev = 1'b1;
          if (mdu_done) state_nxt = RUN;
        end
        DRAIN: begin
          ctl = hold_front(CTRL_RUN);
          if (drain_cnt <= DW'(1)) state_nxt = HALTED;
        end
        HALTED: begin
          ctl = CTRL_OFF;
          if (resume) begin
            ctl.pc_en    = 1'b1;
            ctl.ifid_clr = 1'b1;
            state_nxt    = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      mdu_fin   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_fin <= (state == WAIT_MDU) && mdu_done;
      if (drain_ld)
        drain_cnt <= DW'(DRAIN_CYCLES);
      else if (state == DRAIN)
        drain_cnt <= drain_cnt - DW'(1);
      if (stall_ev) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign {pc_en, ifid_en, ifid_clr, ifid_bb, idex_en, idex_clr, exmem_en, memwb_en} = ctl;
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model checked on
// every falling edge, plus hand-computed literal checks from the main thread.
module tb_pipe_ctrl;

  localparam int CW  = 4;
  localparam int DRN = 3;

  logic          clk, rst;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_use_rs, id_use_rt, ex_memread, ex_br_taken;
  logic          id_mdu_req, mdu_done, id_halt, resume;
  logic          pc_en, ifid_en, ifid_clr, ifid_bb, idex_en, idex_clr, exmem_en, memwb_en;
  logic          mdu_start, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .id_mdu_req(id_mdu_req), .mdu_done(mdu_done), .id_halt(id_halt), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .ifid_bb(ifid_bb),
    .idex_en(idex_en), .idex_clr(idex_clr), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .mdu_start(mdu_start), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: what is in flight, expressed as remaining work.
  bit m_mdu_wait = 0;
  bit m_mdu_fin  = 0;
  bit m_halted   = 0;
  int m_drain    = 0;
  int m_stall    = 0;
  int m_flush    = 0;

  always @(negedge clk) begin
    bit e_pc, e_ifen, e_ifclr, e_idexen, e_idclr, e_exm, e_mwb, e_start, lu;
    bit n_mdu_wait, n_halted;
    int n_drain, n_stall, n_flush;
    if (rst) begin
      m_mdu_wait = 0; m_mdu_fin = 0; m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    end
    {e_pc, e_ifen, e_idexen, e_exm, e_mwb} = 5'b11111;
    {e_ifclr, e_idclr, e_start} = 3'b000;
    n_mdu_wait = m_mdu_wait; n_halted = m_halted; n_drain = m_drain;
    n_stall = m_stall; n_flush = m_flush;
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (rst) begin
    end else if (m_halted) begin
      {e_pc, e_ifen, e_idexen, e_exm, e_mwb} = 5'b00000;
      if (resume) begin e_pc = 1; e_ifclr = 1; n_halted = 0; end
    end else if (m_drain > 0) begin
      e_pc = 0; e_ifen = 0; e_idclr = 1;
      n_drain = m_drain - 1;
      if (n_drain == 0) n_halted = 1;
    end else if (m_mdu_wait) begin
      e_pc = 0; e_ifen = 0; e_idclr = 1; n_stall++;
      if (mdu_done) n_mdu_wait = 0;
    end else if (ex_br_taken) begin
      e_ifclr = 1; e_idclr = 1; n_flush++;
    end else if (lu) begin
      e_pc = 0; e_ifen = 0; e_idclr = 1; n_stall++;
    end else if (id_mdu_req && !m_mdu_fin) begin
      e_pc = 0; e_ifen = 0; e_idclr = 1; e_start = 1; n_stall++; n_mdu_wait = 1;
    end else if (id_halt) begin
      e_pc = 0; e_ifen = 0; e_idclr = 1; n_drain = DRN;
    end
    chk("m.pc_en",     32'(pc_en),     32'(e_pc));
    chk("m.ifid_en",   32'(ifid_en),   32'(e_ifen));
    chk("m.ifid_clr",  32'(ifid_clr),  32'(e_ifclr));
    chk("m.ifid_bb",   32'(ifid_bb),   32'd0);
    chk("m.idex_en",   32'(idex_en),   32'(e_idexen));
    chk("m.idex_clr",  32'(idex_clr),  32'(e_idclr));
    chk("m.exmem_en",  32'(exmem_en),  32'(e_exm));
    chk("m.memwb_en",  32'(memwb_en),  32'(e_mwb));
    chk("m.mdu_start", 32'(mdu_start), 32'(e_start));
    chk("m.halted",    32'(halted),    32'(m_halted));
    chk("m.stall_cnt", 32'(stall_cnt), 32'(m_stall % (1 << CW)));
    chk("m.flush_cnt", 32'(flush_cnt), 32'(m_flush % (1 << CW)));
    if (!rst) begin
      m_mdu_fin  = m_mdu_wait && mdu_done;
      m_mdu_wait = n_mdu_wait; m_halted = n_halted; m_drain = n_drain;
      m_stall = n_stall; m_flush = n_flush;
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0; ex_memread = 0;
    ex_br_taken = 0; id_mdu_req = 0; mdu_done = 0; id_halt = 0; resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int starts;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    chk("reset flush_cnt", 32'(flush_cnt), 0);
    chk("reset pc_en", 32'(pc_en), 1);
    chk("reset mdu_start", 32'(mdu_start), 0);
    chk("reset halted", 32'(halted), 0);

    ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; #1;
    chk("lu pc_en", 32'(pc_en), 0);
    chk("lu ifid_en", 32'(ifid_en), 0);
    chk("lu idex_clr", 32'(idex_clr), 1);
    tick(); idle();
    chk("lu stall_cnt", 32'(stall_cnt), 1);
    ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; #1;
    chk("lu rd0 pc_en", 32'(pc_en), 1);
    tick(); idle();
    chk("lu rd0 stall_cnt", 32'(stall_cnt), 1);
    ex_memread = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1; #1;
    chk("lu rt ifid_en", 32'(ifid_en), 0);
    tick(); idle();
    ex_memread = 1; ex_rd = 9; id_rs = 9; id_use_rs = 0; #1;
    chk("lu unused pc_en", 32'(pc_en), 1);
    tick(); idle();
    ex_memread = 0; ex_rd = 9; id_rs = 9; id_use_rs = 1; #1;
    chk("no load pc_en", 32'(pc_en), 1);
    tick(); idle();
    chk("lu rt stall_cnt", 32'(stall_cnt), 2);

    ex_br_taken = 1; ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; #1;
    chk("flush ifid_clr", 32'(ifid_clr), 1);
    chk("flush idex_clr", 32'(idex_clr), 1);
    chk("flush pc_en", 32'(pc_en), 1);
    tick(); idle();
    chk("flush flush_cnt", 32'(flush_cnt), 1);
    chk("flush stall_cnt", 32'(stall_cnt), 2);
    ex_br_taken = 1; id_mdu_req = 1; id_halt = 1; #1;
    chk("flush no start", 32'(mdu_start), 0);
    tick(); idle();
    chk("flush2 flush_cnt", 32'(flush_cnt), 2);
    mdu_done = 1; #1;
    chk("stray done pc_en", 32'(pc_en), 1);
    tick(); idle();

    id_mdu_req = 1; #1;
    starts = int'(mdu_start);
    chk("mdu start pc_en", 32'(pc_en), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      ex_br_taken = (i == 1);
      mdu_done = (i == 3);
      #1;
      starts += int'(mdu_start);
      chk("mdu wait pc_en", 32'(pc_en), 0);
    end
    tick();
    mdu_done = 0; ex_br_taken = 0; #1;
    chk("mdu exit pc_en", 32'(pc_en), 1);
    chk("mdu exit ifid_en", 32'(ifid_en), 1);
    chk("mdu exit idex_clr", 32'(idex_clr), 0);
    chk("mdu exit start", 32'(mdu_start), 0);
    chk("mdu start pulses", 32'(starts), 1);
    chk("mdu stall_cnt", 32'(stall_cnt), 7);
    chk("mdu flush_cnt", 32'(flush_cnt), 2);
    tick(); idle();

    id_halt = 1; #1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      resume = (i == 2);
      #1;
      chk("halt latency", 32'(halted), (i == 4) ? 1 : 0);
    end
    resume = 0; #1;
    chk("halted pc_en", 32'(pc_en), 0);
    chk("halted ifid_en", 32'(ifid_en), 0);
    chk("halted idex_en", 32'(idex_en), 0);
    chk("halted exmem_en", 32'(exmem_en), 0);
    chk("halted memwb_en", 32'(memwb_en), 0);
    tick();
    chk("halt hold", 32'(halted), 1);
    resume = 1; #1;
    chk("resume ifid_clr", 32'(ifid_clr), 1);
    chk("resume pc_en", 32'(pc_en), 1);
    tick(); idle();
    chk("resume halted", 32'(halted), 0);
    chk("halt stall_cnt", 32'(stall_cnt), 7);

    id_mdu_req = 1;
    tick();
    tick();
    #2 rst = 1;
    #1;
    chk("arst mdu_start", 32'(mdu_start), 0);
    chk("arst stall_cnt", 32'(stall_cnt), 0);
    chk("arst flush_cnt", 32'(flush_cnt), 0);
    chk("arst pc_en", 32'(pc_en), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    idle();
    mdu_done = 1; #1;
    chk("late done pc_en", 32'(pc_en), 1);
    tick(); idle();
    chk("late done stall_cnt", 32'(stall_cnt), 0);

    for (int i = 0; i < 17; i++) begin
      ex_memread = 1; ex_rd = 3; id_rt = 3; id_use_rt = 1;
      tick();
    end
    idle();
    chk("wrap stall_cnt", 32'(stall_cnt), 1);
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage in-order core. It drives the enable, clear and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences load-use stalls, taken-branch flushes, multi-cycle multiply/divide waits and a halt/resume drain. It also keeps stall and flush event counters for performance debug.

## Interface
- `CNT_W`, 32, width of the performance counters.
- `DRAIN_CYCLES`, 3, cycles needed to retire the instructions older than a halt.
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1 each  the ID instruction reads rs / rt.
- `ex_memread`  in  1  the instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_br_taken`  in  1  branch or jump resolved taken in EX.
- `id_mdu_req`  in  1  the ID instruction is mult/div.
- `mdu_done`  in  1  single-cycle done pulse from the MDU.
- `id_halt`  in  1  the ID instruction is halt.
- `resume`  in  1  external resume request.
- `pc_en`  out  1  PC load enable.
- `ifid_en`, `ifid_clr`, `ifid_bb`  out  1 each  IF/ID load, clear and bubble-on-hold controls. The IF/ID register gives CLR priority over EN, and EN priority over bb.
- `idex_en`, `idex_clr`  out  1 each  ID/EX enable and clear.
- `exmem_en`, `memwb_en`  out  1 each  EX/MEM and MEM/WB enables.
- `mdu_start`  out  1  one-cycle MDU start pulse.
- `halted`  out  1  the core is halted.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  event counters.

## Operation
- **Reset values**
  - State RUN.
  - Counters 0.
  - `mdu_start` and `halted` 0.
  - Control outputs take the RUN-normal values: all enables 1, all clears and `ifid_bb` 0.
- **States:** RUN, WAIT_MDU, DRAIN, HALTED.
- **Event priority in RUN:** flush > load-use > MDU > halt > normal.
- **Flush** (`ex_br_taken`):
  - `ifid_clr`=1, `idex_clr`=1, `pc_en`=1.
  - `flush_cnt`+1.
  - No `mdu_start` and no halt entry on this cycle.
- **Load-use** hazard condition: `ex_memread` and `ex_rd`≠0 and (`id_use_rs` and `id_rs`==`ex_rd`, or `id_use_rt` and `id_rt`==`ex_rd`).
  - Outputs: `pc_en`=0, `ifid_en`=0, `ifid_bb`=0 (hold), `idex_clr`=1 (bubble into EX).
  - `stall_cnt`+1.
  - Purely combinational; state stays RUN.
- **MDU request** (`id_mdu_req`):
  - Assert `mdu_start` for one cycle and go to WAIT_MDU.
  - On the start cycle itself, `pc_en`=`ifid_en`=0 and `idex_clr`=1.
- **WAIT_MDU:**
  - `pc_en`=`ifid_en`=0, `ifid_bb`=0, `idex_clr`=1; EX/MEM and MEM/WB keep running so older instructions drain.
  - `stall_cnt`+1 per cycle.
  - On `mdu_done`, return to RUN. The next cycle is normal and the mult/div advances out of ID.
- **Halt** (`id_halt`): enter DRAIN and load the drain counter with `DRAIN_CYCLES`.
- **DRAIN:**
  - `pc_en`=`ifid_en`=0, `idex_clr`=1.
  - Counter decrements each cycle; at 0, go to HALTED.
- **HALTED:**
  - All enables 0, `halted`=1.
  - On `resume`: `ifid_clr`=1 (removes the halt instruction), `pc_en`=1, return to RUN.
- **Ignored inputs:**
  - `mdu_done` outside WAIT_MDU.
  - `resume` outside HALTED.
  - `ex_br_taken` in WAIT_MDU, DRAIN and HALTED; EX holds only bubbles in those states.
- **Counters** wrap modulo 2^CNT_W.
- **Reset mid-operation** (any state, including WAIT_MDU or DRAIN): immediately RUN. `mdu_start` is dropped; the MDU is reset by the same `rst`.

## Timing
- Control outputs are combinational from the current state and the ID/EX inputs; they act at the next `clk` edge.
- State, drain counter and event counters are registered.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs 2 squashed slots (IF/ID and ID/EX).
- MDU stall length = cycles from `mdu_start` to `mdu_done`, plus 1 for the start cycle.
- Halt to `halted`=1 latency: `DRAIN_CYCLES`+1 cycles.
- Resume takes effect on the edge where `resume` is sampled high in HALTED.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, WAIT_MDU, DRAIN, HALTED);
  - the default for `DRAIN_CYCLES`;
  - a packed control-bundle typedef for the stage enables and clears.
- Sub-module `hazard_detect`: combinational load-use comparator producing `lu_stall`.

## Test plan
- **Load-use:** `ex_memread`=1, `ex_rd`=5, `id_rs`=5, `id_use_rs`=1 → for 1 cycle `pc_en`=0, `ifid_en`=0, `idex_clr`=1; `stall_cnt` becomes 1. Same stimulus with `ex_rd`=0 → no stall.
- **Flush beats load-use:** `ex_br_taken`=1 together with a load-use hit → `ifid_clr`=`idex_clr`=1, `pc_en`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- **MDU wait:** `id_mdu_req`=1, `mdu_done` 4 cycles after start → `mdu_start` pulses once, 5 stall cycles counted, then RUN with all enables 1.
- **Halt and resume:** `id_halt`=1 → `halted`=1 after 4 cycles, all enables 0. `resume`=1 → `ifid_clr`=1 and `pc_en`=1 that cycle, `halted`=0 the next.
- **Reset mid-operation:** `rst` asserted asynchronously mid-WAIT_MDU → immediately RUN, counters 0, `mdu_start`=0. A late `mdu_done` afterwards is ignored.
- **Counter wrap:** with `CNT_W`=4, 17 load-use stalls → `stall_cnt`=1.
